add_sub_cla_mantissa: RTL and testbench

- 24-bit sign-magnitude mantissa adder/subtractor for the single-precision FPU add/sub stage 2; sits after exponent alignment, before normalization.
- Decides effective operation from the operand signs and the op select, then adds, or subtracts man_y from man_x.
- Uses a three-level carry-lookahead tree: 4-bit CLA blocks, 6 groups, then 2 super-groups.
- Result and carry are registered with a one-cycle latency and a valid flag.

---
 rtl/add_sub_cla_mantissa.sv | 167 ++++++++++++++++
 tb/tb_add_sub_cla_mantissa.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/add_sub_cla_mantissa.sv
// 24-bit sign-magnitude mantissa adder/subtractor with a 3-level CLA tree (6x4 / 2x3), registered output.
// Define ADDSUB_INPUT_REG_EN to register the operands before the CLA (2-cycle latency instead of 1).
module add_sub_cla_mantissa #(
  parameter int NORMALIZE_MANTISSA_LENGTH = 24
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_x,
  input  logic [NORMALIZE_MANTISSA_LENGTH-1:0] man_y,
  input  logic                                 sign_x,
  input  logic                                 sign_y,
  input  logic                                 add_sub,
  output logic [NORMALIZE_MANTISSA_LENGTH-1:0] result,
  output logic                                 cout,
  output logic                                 out_valid
);

  // 4-bit lookahead block: returns {group_p, group_g, carry_in[3:0]}
  function automatic logic [5:0] cla4(input logic [3:0] g, input logic [3:0] p, input logic cin);
    logic [3:0] c;
    logic       pg;
    logic       gg;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    pg   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {pg, gg, c};
  endfunction

  // 3-group lookahead unit: returns {super_p, super_g, group_carry[2:0]}
  function automatic logic [4:0] cla3(input logic [2:0] g, input logic [2:0] p, input logic cin);
    logic [2:0] c;
    logic       pg;
    logic       gg;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    pg   = &p;
    gg   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]);
    return {pg, gg, c};
  endfunction

  logic [23:0] x_s, y_s;
  logic        sx_s, sy_s, op_s, vld_s;

`ifdef ADDSUB_INPUT_REG_EN
  logic [23:0] x_q, y_q;
  logic        sx_q, sy_q, op_q, vld_q;

  // operand capture stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q   <= 24'h000000;
      y_q   <= 24'h000000;
      sx_q  <= 1'b0;
      sy_q  <= 1'b0;
      op_q  <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      x_q   <= man_x;
      y_q   <= man_y;
      sx_q  <= sign_x;
      sy_q  <= sign_y;
      op_q  <= add_sub;
      vld_q <= in_valid;
    end
  end

  // CLA operand select: registered copies
  always_comb begin
    x_s   = x_q;
    y_s   = y_q;
    sx_s  = sx_q;
    sy_s  = sy_q;
    op_s  = op_q;
    vld_s = vld_q;
  end
`else
  // CLA operand select: ports feed the tree directly
  always_comb begin
    x_s   = man_x;
    y_s   = man_y;
    sx_s  = sign_x;
    sy_s  = sign_y;
    op_s  = add_sub;
    vld_s = in_valid;
  end
`endif

  logic        operate_s, c0_s, cout_s;
  logic [23:0] b_s, g_s, p_s, c_in_s, sum_s;
  logic [5:0]  pin_l2_s, gin_l2_s, cout_l2_s;
  logic [1:0]  pin_l3_s, gin_l3_s, cout_l3_s;
  logic [5:0]  l1_s;
  logic [4:0]  l2_s;

  // Group P/G are carry-independent, so they are resolved bottom-up before carries flow top-down
  always_comb begin
    operate_s = sx_s ^ sy_s ^ op_s;
    c0_s      = operate_s;
    b_s       = y_s ^ {24{operate_s}};
    g_s       = x_s & b_s;
    p_s       = x_s ^ b_s;
    pin_l2_s  = 6'd0;
    gin_l2_s  = 6'd0;
    cout_l2_s = 6'd0;
    pin_l3_s  = 2'd0;
    gin_l3_s  = 2'd0;
    cout_l3_s = 2'd0;
    c_in_s    = 24'h000000;
    l1_s      = 6'd0;
    l2_s      = 5'd0;
    for (int k = 0; k < 6; k++) begin
      l1_s        = cla4(g_s[4*k +: 4], p_s[4*k +: 4], 1'b0);
      pin_l2_s[k] = l1_s[5];
      gin_l2_s[k] = l1_s[4];
    end
    for (int j = 0; j < 2; j++) begin
      l2_s        = cla3(gin_l2_s[3*j +: 3], pin_l2_s[3*j +: 3], 1'b0);
      pin_l3_s[j] = l2_s[4];
      gin_l3_s[j] = l2_s[3];
    end
    cout_l3_s[0] = c0_s;
    cout_l3_s[1] = gin_l3_s[0] | (pin_l3_s[0] & c0_s);
    for (int j = 0; j < 2; j++) begin
      l2_s                 = cla3(gin_l2_s[3*j +: 3], pin_l2_s[3*j +: 3], cout_l3_s[j]);
      cout_l2_s[3*j +: 3]  = l2_s[2:0];
    end
    for (int k = 0; k < 6; k++) begin
      l1_s               = cla4(g_s[4*k +: 4], p_s[4*k +: 4], cout_l2_s[k]);
      c_in_s[4*k +: 4]   = l1_s[3:0];
    end
    sum_s  = p_s ^ c_in_s;
    cout_s = gin_l3_s[1] | (pin_l3_s[1] & cout_l3_s[1]);
  end

  logic [23:0] result_d, result_q;
  logic        cout_d, cout_q, out_valid_d, out_valid_q;

  // output register next-state
  always_comb begin
    result_d    = sum_s;
    cout_d      = cout_s;
    out_valid_d = vld_s;
  end

  // output register; data loads every cycle, valid qualifies it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= 24'h000000;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_add_sub_cla_mantissa.sv
// Self-checking bench for add_sub_cla_mantissa: directed spec vectors, random stream against an arithmetic model, async reset.
module tb_add_sub_cla_mantissa;

`ifdef ADDSUB_INPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [23:0] man_x = 24'h0, man_y = 24'h0;
  logic        sign_x = 1'b0, sign_y = 1'b0, add_sub = 1'b0;
  logic [23:0] result;
  logic        cout, out_valid;

  int vectors = 0;
  int miscompares = 0;

  add_sub_cla_mantissa dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .man_x(man_x), .man_y(man_y), .sign_x(sign_x), .sign_y(sign_y), .add_sub(add_sub),
    .result(result), .cout(cout), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Reference: effective op from signs, then plain integer add or subtract
  function automatic logic [24:0] ref_model(input logic [23:0] x, input logic [23:0] y,
                                            input logic sx, input logic sy, input logic op);
    logic [24:0] r;
    if (sx ^ sy ^ op) begin
      r[23:0] = x - y;
      r[24]   = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  // Present one valid operand set, then wait out the pipeline latency
  task automatic drive_one(input logic [23:0] x, input logic [23:0] y,
                           input logic sx, input logic sy, input logic op);
    man_x = x; man_y = y; sign_x = sx; sign_y = sy; add_sub = op; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (LAT - 1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    #3;
    vectors++;
    if (result !== 24'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: got result=%h cout=%b valid=%b, want 000000/0/0", result, cout, out_valid);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    logic [23:0] tx[13], ty[13], te[13];
    logic        tsx[13], tsy[13], top[13], tc[13];
    tx = '{24'hB30967, 24'hB30967, 24'hB30967, 24'hB30967, 24'hB30967, 24'hB30967, 24'hB30967,
           24'hB30967, 24'h800000, 24'h940000, 24'hFFFFFF, 24'h123456, 24'h000001};
    ty = '{24'h4AD278, 24'h4AD278, 24'h4AD278, 24'h4AD278, 24'h8FA6E1, 24'h8FA6E1, 24'h8FA6E1,
           24'h8FA6E1, 24'h580000, 24'h000410, 24'h000001, 24'h123456, 24'h000002};
    tsx = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tsy = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    top = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    te = '{24'hFDDBDF, 24'h6836EF, 24'h6836EF, 24'hFDDBDF, 24'h42B048, 24'h42B048, 24'h236286,
           24'h236286, 24'h280000, 24'h93FBF0, 24'h000000, 24'h000000, 24'hFFFFFF};
    tc = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      drive_one(tx[i], ty[i], tsx[i], tsy[i], top[i]);
      vectors++;
      if (result !== te[i] || cout !== tc[i] || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL directed_%0d: got result=%h cout=%b valid=%b, want %h/%b/1",
                 i, result, cout, out_valid, te[i], tc[i]);
      end
    end
    @(posedge clk); #1;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_drop: got out_valid=%b, want 0", out_valid);
    end
  endtask

  task automatic test_back_to_back;
    logic [25:0] q[$];
    logic [25:0] exp_v;
    logic [23:0] x, y;
    logic        sx, sy, op, v;
    for (int n = 0; n < 300; n++) begin
      x  = 24'($urandom);
      y  = (n % 3 == 0) ? 24'($urandom) : (x >> $urandom_range(0, 23));
      sx = 1'($urandom); sy = 1'($urandom); op = 1'($urandom); v = 1'($urandom);
      man_x = x; man_y = y; sign_x = sx; sign_y = sy; add_sub = op; in_valid = v;
      q.push_back({v, ref_model(x, y, sx, sy, op)});
      @(posedge clk); #1;
      if (q.size() == LAT) begin
        exp_v = q.pop_front();
        vectors++;
        if (result !== exp_v[23:0] || cout !== exp_v[24] || out_valid !== exp_v[25]) begin
          miscompares++;
          $display("FAIL stream_%0d: got result=%h cout=%b valid=%b, want %h/%b/%b",
                   n, result, cout, out_valid, exp_v[23:0], exp_v[24], exp_v[25]);
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset;
    man_x = 24'hFFFFFF; man_y = 24'h000001; sign_x = 1'b0; sign_y = 1'b0; add_sub = 1'b0;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    vectors++;
    if (result !== 24'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got result=%h cout=%b valid=%b, want 000000/0/0", result, cout, out_valid);
    end
    repeat (2) @(posedge clk); #1;
    vectors++;
    if (result !== 24'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: got result=%h cout=%b valid=%b, want 000000/0/0", result, cout, out_valid);
    end
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    drive_one(24'h800000, 24'h580000, 1'b0, 1'b1, 1'b0);
    vectors++;
    if (result !== 24'h280000 || cout !== 1'b1 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL post_reset: got result=%h cout=%b valid=%b, want 280000/1/1", result, cout, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
